// File: rtl/ins_sequencer_if.sv
// Instruction sequencer bus: the instruction RAM read port plus the
// valid/ready instruction stream offered to the top-level controller.
interface ins_sequencer_if #(
  parameter int INST_W = 64,
  parameter int ADDR_W = 10
) ();

  // Instruction RAM read port (data returns one cycle after the strobe)
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [INST_W-1:0] ram_rd_data;

  // Instruction stream towards the controller
  logic              ins_valid;
  logic              ins_ready;
  logic [INST_W-1:0] ins;

  // Sequencer side
  modport master (
    output ram_rd_en,
    output ram_rd_addr,
    input  ram_rd_data,
    output ins_valid,
    output ins,
    input  ins_ready
  );

  // RAM / controller side
  modport slave (
    input  ram_rd_en,
    input  ram_rd_addr,
    output ram_rd_data,
    input  ins_valid,
    input  ins,
    output ins_ready
  );

endinterface

// File: rtl/ins_sequencer.sv
// Instruction sequencer: fetches a program of i_ins_num words starting at
// i_ins_base from the instruction RAM, buffers them in a 2-entry FIFO and
// hands them to the controller over a valid/ready stream. After the last
// instruction is accepted it waits for the controller to go idle, then
// pulses o_done.
module ins_sequencer #(
  parameter int INST_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_ins_base,
  input  logic [ADDR_W-1:0] i_ins_num,
  input  logic              i_working,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_issued_cnt,
  ins_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // Program bookkeeping
  logic [ADDR_W-1:0] r_rd_addr;     // next RAM address to read (wraps)
  logic [ADDR_W-1:0] r_num;         // instruction count of this program
  logic [ADDR_W-1:0] r_rd_cnt;      // reads issued so far
  logic [ADDR_W-1:0] r_issued_cnt;  // instructions accepted so far
  logic              r_inflight;    // a read was issued last cycle
  logic              r_low_seen;    // working was low on the previous DRAIN cycle

  // 2-entry instruction FIFO
  logic [INST_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_flush;
  logic              w_last;
  logic              w_rd_en;
  logic              w_done;
  logic              w_busy;
  logic              w_launch;
  logic [2:0]        w_pending;
  logic [ADDR_W-1:0] w_issued_inc;

  assign w_valid      = (r_count != 2'd0);
  assign w_pop        = w_valid && bus.ins_ready;
  assign w_launch     = (r_state == S_IDLE) && i_start;
  // Abort only has meaning while a program is active; in IDLE it is ignored.
  assign w_flush      = (r_state != S_IDLE) && i_abort;
  // Returning read data is dropped in the cycle an abort flushes the FIFO.
  assign w_push       = r_inflight && !w_flush;
  assign w_issued_inc = r_issued_cnt + 1'b1;
  assign w_last       = w_pop && (w_issued_inc == r_num);

  // Words that will be held or still arriving once this cycle's pop is done.
  // Counting the concurrent pop lets a new read go out every cycle while the
  // controller keeps accepting, yet never overfills the 2-entry FIFO.
  assign w_pending    = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus read strobe, busy and done generation
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // An empty program skips straight to waiting for the controller.
          w_state_next = (i_ins_num != '0) ? S_RUN : S_DRAIN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else begin
          w_rd_en = (r_rd_cnt != r_num) && (w_pending < 3'd2);
          if (w_last) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (!i_working && r_low_seen) begin
          // Two consecutive idle samples ride out the controller's status lag.
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = !i_abort;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Program counters, read tracking and FIFO occupancy/pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr    <= '0;
      r_num        <= '0;
      r_rd_cnt     <= '0;
      r_issued_cnt <= '0;
      r_inflight   <= 1'b0;
      r_low_seen   <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
    end else if (w_launch) begin
      r_rd_addr    <= i_ins_base;
      r_num        <= i_ins_num;
      r_rd_cnt     <= '0;
      r_issued_cnt <= '0;
      r_inflight   <= 1'b0;
      r_low_seen   <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_inflight <= w_rd_en;
      r_low_seen <= (r_state == S_DRAIN) && !i_working;
      if (w_rd_en) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        r_rd_cnt  <= r_rd_cnt + 1'b1;
      end
      // A handshake in the abort cycle still happened, so it is counted.
      if (w_pop) begin
        r_issued_cnt <= w_issued_inc;
      end
      if (w_flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  // FIFO storage: each entry captures returning RAM data when it is the write slot
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_fifo[gi] <= '0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_fifo[gi] <= bus.ram_rd_data;
      end
    end
  end

  assign bus.ram_rd_en   = w_rd_en;
  assign bus.ram_rd_addr = r_rd_addr;
  assign bus.ins_valid   = w_valid;
  // Head of FIFO; forced to zero when nothing is offered.
  assign bus.ins         = w_valid ? r_fifo[r_rd_ptr] : '0;

  assign o_busy          = w_busy;
  assign o_done          = w_done;
  assign o_issued_cnt    = r_issued_cnt;

endmodule

// File: tb/tb_ins_sequencer.sv
// Directed testbench for ins_sequencer with a one-cycle-latency RAM model.
module tb_ins_sequencer;

  localparam int INST_W = 64;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] ins_base;
  logic [ADDR_W-1:0] ins_num;
  logic              working;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] issued_cnt;

  ins_sequencer_if #(.INST_W(INST_W), .ADDR_W(ADDR_W)) bus ();

  ins_sequencer #(.INST_W(INST_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_ins_base   (ins_base),
    .i_ins_num    (ins_num),
    .i_working    (working),
    .o_busy       (busy),
    .o_done       (done),
    .o_issued_cnt (issued_cnt),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known RAM contents: every address holds a distinct word.
  function automatic logic [63:0] ram_word(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a, 22'h155555, a};
  endfunction

  // RAM model: data valid exactly one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= ram_word(bus.ram_rd_addr);
  end

  // Monitor logs
  int          cyc = 0;
  int          s_cyc = 0;
  int          valid_cnt = 0;
  int          stab_err = 0;
  logic        hold_prev = 1'b0;
  logic        abort_prev = 1'b0;
  logic [63:0] ins_prev = '0;
  logic [9:0]  rd_log[$];
  logic [63:0] acc_log[$];
  int          acc_cyc[$];
  int          done_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (start) s_cyc <= cyc;
      if (bus.ram_rd_en) rd_log.push_back(bus.ram_rd_addr);
      if (bus.ins_valid) valid_cnt <= valid_cnt + 1;
      if (bus.ins_valid && bus.ins_ready) begin
        acc_log.push_back(bus.ins);
        acc_cyc.push_back(cyc);
        $display("accept cyc=%0d ins=%h", cyc, bus.ins);
      end
      if (done) done_cyc.push_back(cyc);
      // Offered instruction must stay put until it is taken (abort excepted)
      if (hold_prev && !abort_prev && !(bus.ins_valid && bus.ins == ins_prev))
        stab_err <= stab_err + 1;
      hold_prev  <= bus.ins_valid && !bus.ins_ready;
      abort_prev <= abort;
      ins_prev   <= bus.ins;
    end else begin
      hold_prev  <= 1'b0;
      abort_prev <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  int rb, ab, db, vb, sb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    rb = rd_log.size();
    ab = acc_log.size();
    db = done_cyc.size();
    vb = valid_cnt;
    sb = stab_err;
  endtask

  // Drive a one-cycle start; returns in cycle 1 after the sampling edge.
  task automatic start_prog(input logic [9:0] b, input logic [9:0] n);
    $display("start base=%h num=%0d", b, n);
    start    = 1'b1;
    ins_base = b;
    ins_num  = n;
    tick();
    start = 1'b0;
  endtask

  task automatic check_prog(input string tag, input logic [9:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_rd%0d", tag, i), 64'(rd_log[rb+i]), 64'(10'(b + i)));
      check($sformatf("%s_ins%0d", tag, i), acc_log[ab+i], ram_word(10'(b + i)));
    end
    check({tag, "_nrd"}, 64'(rd_log.size() - rb), 64'(n));
    check({tag, "_nacc"}, 64'(acc_log.size() - ab), 64'(n));
    check({tag, "_issued"}, 64'(issued_cnt), 64'(n));
    check({tag, "_ndone"}, 64'(done_cyc.size() - db), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    ins_base = '0; ins_num = '0; working = 1'b0;
    bus.ins_ready = 1'b0;
    repeat (3) tick();
    check("rst_rd_en", 64'(bus.ram_rd_en), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_rd_addr", 64'(bus.ram_rd_addr), 64'd0);
    check("rst_valid", 64'(bus.ins_valid), 64'd0);
    check("rst_ins", bus.ins, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_issued", 64'(issued_cnt), 64'd0);

    // Basic program, controller always ready
    bus.ins_ready = 1'b1;
    mark();
    start_prog(10'h010, 10'd3);
    check("t1_busy_c1", 64'(busy), 64'd1);
    check("t1_valid_c1", 64'(bus.ins_valid), 64'd0);
    repeat (14) tick();
    check_prog("t1", 10'h010, 3);
    check("t1_first_lat", 64'(acc_cyc[ab] - s_cyc), 64'd3);
    check("t1_back2back", 64'(acc_cyc[ab+2] - acc_cyc[ab]), 64'd2);
    check("t1_done_lat", 64'(done_cyc[db] - s_cyc), 64'd8);
    check("t1_busy_end", 64'(busy), 64'd0);

    // Address wrap past the top of the RAM
    mark();
    start_prog(10'h3FE, 10'd4);
    repeat (16) tick();
    check_prog("t2", 10'h3FE, 4);

    // Back-pressure, with an ignored start mid-program
    bus.ins_ready = 1'b0;
    mark();
    start_prog(10'h100, 10'd5);
    repeat (4) tick();
    start = 1'b1; ins_base = 10'h3AA; ins_num = 10'd1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("t3_stall_nrd", 64'(rd_log.size() - rb), 64'd2);
    check("t3_stall_valid", 64'(bus.ins_valid), 64'd1);
    check("t3_stall_ins", bus.ins, ram_word(10'h100));
    check("t3_stall_issued", 64'(issued_cnt), 64'd0);
    bus.ins_ready = 1'b1;
    repeat (16) tick();
    check_prog("t3", 10'h100, 5);
    check("t3_stable", 64'(stab_err - sb), 64'd0);

    // Controller still working after the last instruction
    working = 1'b1;
    mark();
    start_prog(10'h200, 10'd2);
    repeat (9) tick();
    check("t4_busy_working", 64'(busy), 64'd1);
    check("t4_no_done_yet", 64'(done_cyc.size() - db), 64'd0);
    tick();
    working = 1'b0;
    check("t4_busy_low1", 64'(busy), 64'd1);
    repeat (8) tick();
    check_prog("t4", 10'h200, 2);
    check("t4_done_lat", 64'(done_cyc[db] - s_cyc), 64'd13);

    // Abort after two instructions, then a fresh program
    mark();
    start_prog(10'h300, 10'd6);
    repeat (4) tick();
    bus.ins_ready = 1'b0;
    abort = 1'b1;
    check("t5_valid_pre", 64'(bus.ins_valid), 64'd1);
    tick();
    abort = 1'b0;
    check("t5_valid_post", 64'(bus.ins_valid), 64'd0);
    check("t5_busy_post", 64'(busy), 64'd0);
    check("t5_issued", 64'(issued_cnt), 64'd2);
    repeat (10) tick();
    check("t5_no_done", 64'(done_cyc.size() - db), 64'd0);
    check("t5_nacc", 64'(acc_log.size() - ab), 64'd2);
    check("t5_ins0", acc_log[ab], ram_word(10'h300));
    check("t5_ins1", acc_log[ab+1], ram_word(10'h301));
    check("t5_issued_kept", 64'(issued_cnt), 64'd2);
    bus.ins_ready = 1'b1;
    mark();
    start_prog(10'h050, 10'd2);
    repeat (12) tick();
    check_prog("t5b", 10'h050, 2);

    // Empty program
    mark();
    start_prog(10'h123, 10'd0);
    repeat (8) tick();
    check("t6_nrd", 64'(rd_log.size() - rb), 64'd0);
    check("t6_nvalid", 64'(valid_cnt - vb), 64'd0);
    check("t6_ndone", 64'(done_cyc.size() - db), 64'd1);
    check("t6_done_lat", 64'(done_cyc[db] - s_cyc), 64'd3);

    // Reset in the middle of a stalled program
    bus.ins_ready = 1'b0;
    mark();
    start_prog(10'h080, 10'd5);
    repeat (4) tick();
    check("t7_valid_pre", 64'(bus.ins_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rd_en", 64'(bus.ram_rd_en), 64'd0);
    check("t7_rd_addr", 64'(bus.ram_rd_addr), 64'd0);
    check("t7_valid", 64'(bus.ins_valid), 64'd0);
    check("t7_ins", bus.ins, 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_done", 64'(done), 64'd0);
    check("t7_issued", 64'(issued_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.ins_ready = 1'b1;
    repeat (8) tick();
    check("t7_idle_busy", 64'(busy), 64'd0);
    check("t7_idle_nrd", 64'(rd_log.size() - rb), 64'd2);
    check("t7_idle_ndone", 64'(done_cyc.size() - db), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
